alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised-width, handshaked ALU for the multi-cycle CPU datapath.
- Executes the existing single-cycle op set (ADD..BGTZ, same encodings) with a registered result.
- Adds iterative unsigned multiply, divide and remainder.
- Sits between decode/regfile read and writeback; valid/ready on both sides lets the controller stall on long ops.

Parameters:
- WIDTH, 32: operand/result width; power of 2, >= 8. Local SHW = clog2(WIDTH).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/op valid
- in_ready  out  1  block can accept an op
- aluop  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 LUI, 10 SLT, 11 SLTU, 12 BGTZ, 13 MULU, 14 DIVU, 15 REMU
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B / shift amount
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- c  out  WIDTH  result
- c_hi  out  WIDTH  MULU upper product half; 0 for all other ops
- flag  out  2  [0]: c == 0; [1]: $signed(a) > 0, evaluated on the accepted a

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; in_ready = 1; out_valid = 0; c = 0; c_hi = 0; flag = 0.
  - Takes effect immediately, including mid-iteration; the in-flight op is discarded.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready = 1. Accept when in_valid & in_ready.
    - Ops 0-12 → DONE next edge.
    - MULU/DIVU/REMU with b != 0 → BUSY, counter = WIDTH.
    - DIVU/REMU with b == 0 → DONE next edge.
  - BUSY: in_ready = 0. One iteration per cycle; counter decrements; at counter == 1 the edge loads results → DONE.
  - DONE: out_valid = 1; c, c_hi, flag held stable. out_ready high → IDLE next edge. No accept in DONE.
- Latency (accept edge = cycle 0):
  - Single-cycle ops and div-by-zero: out_valid at cycle 1.
  - MULU/DIVU/REMU: out_valid at cycle WIDTH+1.
  - Throughput: at most one op per 2 cycles.
- Arithmetic, all mod 2^WIDTH:
  - ADD/SUB wrap, no overflow flag.
  - Shifts use b[SHW-1:0]. SRA is arithmetic on signed a.
  - LUI: c = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
  - SLT signed / SLTU unsigned: c = 1 or 0.
  - BGTZ: c = ($signed(a) > 0).
- Multiply: unsigned shift-add over 2*WIDTH product. c = low half, c_hi = high half.
- Divide: unsigned restoring, one quotient bit per cycle. DIVU c = quotient; REMU c = remainder. c_hi = 0.
- Divide by zero: DIVU c = all ones; REMU c = a.
- Operands a, b, aluop are captured at accept; later input changes have no effect.
- in_valid while busy: ignored (in_ready = 0); the source must hold.
- flag[0] is computed from the final c.

Test Plan:
- Timing: ADD a=5, b=4 → c=9, flag=2'b10, out_valid exactly 1 cycle after accept. SUB 5-5 → c=0, flag[0]=1.
- Shifts: SLL a=0xFF000000, b=4 → c=0xF0000000. SRA same operands → c=0xFFF00000. SRL → c=0x0FF00000. SLT a=0xFFFFFFFF, b=0 → c=1. SLTU same → c=0.
- MULU a=0x00010000, b=0x00010000 → c=0, c_hi=1, out_valid at cycle 33. in_ready=0 for cycles 1-33. Input changes during BUSY do not affect the result.
- Divide: DIVU 100/7 → c=14; REMU 100/7 → c=2, both at cycle 33. DIVU 5/0 → c=0xFFFFFFFF at cycle 1; REMU 5/0 → c=5.
- Backpressure: XOR 0x0F0F0F0F,0x0C0C0C0C with out_ready low for 5 cycles → c=0x03030303 held stable, out_valid high, in_ready low throughout. out_ready high → IDLE next edge.
- Reset mid-op: rst_n low at cycle 10 of MULU → out_valid=0, c=0 immediately. After release, in_ready=1 and BGTZ a=5 → c=1, flag[1]=1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU for the multi-cycle datapath.
// Single-cycle ops finish on the accept edge. MULU/DIVU/REMU iterate
// one bit per cycle. The accepted operands are held locally, so the
// source may change its inputs once the op has been taken.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_hi,
  output logic [1:0]       flag
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_LUI  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;
  localparam logic [3:0] OP_BGTZ = 4'd12;
  localparam logic [3:0] OP_MULU = 4'd13;
  localparam logic [3:0] OP_DIVU = 4'd14;

  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] chi_q, chi_d;
  logic [1:0]       flag_q, flag_d;

  logic [WIDTH-1:0] simpleRes;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulHiNxt, mulLoNxt;
  logic [WIDTH:0]   divShift, divTrial;
  logic             divQbit;
  logic [WIDTH-1:0] divRemNxt, divLoNxt;
  logic [WIDTH-1:0] finalRes;

  // Single-cycle op results, taken straight from the inputs at accept.
  always_comb begin
    simpleRes = '0;
    shamt     = b[SHW-1:0];
    case (aluop)
      OP_ADD:  simpleRes = a + b;
      OP_SUB:  simpleRes = a - b;
      OP_AND:  simpleRes = a & b;
      OP_OR:   simpleRes = a | b;
      OP_XOR:  simpleRes = a ^ b;
      OP_NOR:  simpleRes = ~(a | b);
      OP_SLL:  simpleRes = a << shamt;
      OP_SRL:  simpleRes = a >> shamt;
      OP_SRA:  simpleRes = $unsigned($signed(a) >>> shamt);
      OP_LUI:  simpleRes = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLT:  simpleRes = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: simpleRes = {{(WIDTH-1){1'b0}}, a < b};
      OP_BGTZ: simpleRes = {{(WIDTH-1){1'b0}}, $signed(a) > 0};
      default: simpleRes = '0;
    endcase
  end

  // One shift-add multiply step and one restoring divide step on hi/lo.
  always_comb begin
    mulSum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mulHiNxt  = mulSum[WIDTH:1];
    mulLoNxt  = {mulSum[0], lo_q[WIDTH-1:1]};
    divShift  = {hi_q, lo_q[WIDTH-1]};
    divTrial  = divShift - {1'b0, opnd_q};
    divQbit   = ~divTrial[WIDTH];
    divRemNxt = divQbit ? divTrial[WIDTH-1:0] : divShift[WIDTH-1:0];
    divLoNxt  = {lo_q[WIDTH-2:0], divQbit};
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    c_d       = c_q;
    chi_d     = chi_q;
    flag_d    = flag_q;
    finalRes  = '0;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d   = aluop;
          chi_d  = '0;
          flag_d = {($signed(a) > 0), 1'b0};
          if (aluop == OP_MULU) begin
            opnd_d  = a;
            hi_d    = '0;
            lo_d    = b;
            cnt_d   = CNT_INIT;
            state_d = BUSY;
          end else if (aluop > OP_MULU && b != '0) begin
            opnd_d  = b;
            hi_d    = '0;
            lo_d    = a;
            cnt_d   = CNT_INIT;
            state_d = BUSY;
          end else begin
            if (aluop == OP_DIVU)
              finalRes = '1;
            else if (aluop > OP_DIVU)
              finalRes = a;
            else
              finalRes = simpleRes;
            c_d       = finalRes;
            flag_d[0] = (finalRes == '0);
            state_d   = DONE;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (op_q == OP_MULU) begin
          hi_d     = mulHiNxt;
          lo_d     = mulLoNxt;
          finalRes = mulLoNxt;
        end else begin
          hi_d     = divRemNxt;
          lo_d     = divLoNxt;
          finalRes = (op_q == OP_DIVU) ? divLoNxt : divRemNxt;
        end
        if (cnt_q == CNT_ONE) begin
          c_d       = finalRes;
          chi_d     = (op_q == OP_MULU) ? mulHiNxt : '0;
          flag_d[0] = (finalRes == '0);
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight op at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      chi_q   <= '0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      chi_q   <= chi_d;
      flag_q  <= flag_d;
    end
  end

  assign c    = c_q;
  assign c_hi = chi_q;
  assign flag = flag_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  aluop;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic [31:0] c_hi;
  logic [1:0]  flag;

  int checks;
  int failures;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .c_hi      (c_hi),
    .flag      (flag)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one op for a single accept edge, then scramble the inputs.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] opA,
                               input logic [31:0] opB);
    @(negedge clk);
    aluop    = op;
    a        = opA;
    b        = opB;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    aluop    = 4'd0;
    a        = 32'hDEADBEEF;
    b        = 32'h00000003;
  endtask

  // Run an op to completion, check result, latency and handshake, then drain.
  task automatic doOp(input string tag, input logic [3:0] op,
                      input logic [31:0] opA, input logic [31:0] opB,
                      input logic [31:0] expC, input logic [31:0] expHi,
                      input logic [1:0] expFlag, input int expLat);
    int   lat;
    logic anyReady;
    applyStimulus(op, opA, opB);
    lat      = 1;
    anyReady = in_ready;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      anyReady = anyReady | in_ready;
    end
    checkOutput({tag, "_lat"}, 64'(lat), 64'(expLat));
    checkOutput({tag, "_rdy_busy"}, 64'(anyReady), 64'd0);
    checkOutput({tag, "_c"}, 64'(c), 64'(expC));
    checkOutput({tag, "_chi"}, 64'(c_hi), 64'(expHi));
    checkOutput({tag, "_flag"}, 64'(flag), 64'(expFlag));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_idle"}, {62'd0, in_ready, out_valid}, 64'h2);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    aluop     = 4'd0;
    a         = '0;
    b         = '0;
    #12;
    checkOutput("rst_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_c", 64'(c), 64'd0);
    checkOutput("rst_chi", 64'(c_hi), 64'd0);
    checkOutput("rst_flag", 64'(flag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    doOp("add",  4'd0,  32'd5, 32'd4, 32'd9, 32'd0, 2'b10, 1);
    doOp("sub",  4'd1,  32'd5, 32'd5, 32'd0, 32'd0, 2'b11, 1);
    doOp("and",  4'd2,  32'h0F0F00FF, 32'h00FF0F0F, 32'h000F000F, 32'd0, 2'b10, 1);
    doOp("or",   4'd3,  32'h0F0F0000, 32'h00FF0000, 32'h0FFF0000, 32'd0, 2'b10, 1);
    doOp("nor",  4'd5,  32'h0F0F0F0F, 32'hF0F00000, 32'h0000F0F0, 32'd0, 2'b10, 1);
    doOp("sll",  4'd6,  32'hFF000000, 32'd4, 32'hF0000000, 32'd0, 2'b00, 1);
    doOp("srl",  4'd7,  32'hFF000000, 32'd4, 32'h0FF00000, 32'd0, 2'b00, 1);
    doOp("sra",  4'd8,  32'hFF000000, 32'd4, 32'hFFF00000, 32'd0, 2'b00, 1);
    doOp("sllw", 4'd6,  32'h00000001, 32'h00000025, 32'h00000020, 32'd0, 2'b10, 1);
    doOp("lui",  4'd9,  32'd0, 32'hABCD1234, 32'h12340000, 32'd0, 2'b00, 1);
    doOp("slt",  4'd10, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd0, 2'b00, 1);
    doOp("sltu", 4'd11, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 2'b01, 1);
    doOp("bgtz0", 4'd12, 32'd0, 32'd0, 32'd0, 32'd0, 2'b01, 1);
    doOp("mulu", 4'd13, 32'h00010000, 32'h00010000, 32'd0, 32'd1, 2'b11, 33);
    doOp("mulmax", 4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 2'b00, 33);
    doOp("divu", 4'd14, 32'd100, 32'd7, 32'd14, 32'd0, 2'b10, 33);
    doOp("remu", 4'd15, 32'd100, 32'd7, 32'd2, 32'd0, 2'b10, 33);
    doOp("divbig", 4'd14, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'd0, 2'b00, 33);
    doOp("remz", 4'd15, 32'd21, 32'd7, 32'd0, 32'd0, 2'b11, 33);
    doOp("div0", 4'd14, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd0, 2'b10, 1);
    doOp("rem0", 4'd15, 32'd5, 32'd0, 32'd5, 32'd0, 2'b10, 1);

    // Backpressure: result must hold while the consumer is not ready.
    applyStimulus(4'd4, 32'h0F0F0F0F, 32'h0C0C0C0C);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_c%0d", i), 64'(c), 64'h03030303);
      checkOutput($sformatf("bp_hs%0d", i), {62'd0, in_ready, out_valid}, 64'h1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp_release", {62'd0, in_ready, out_valid}, 64'h2);

    // Asynchronous reset in the middle of a multiply.
    applyStimulus(4'd13, 32'h00010000, 32'h00010000);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_valid", 64'(out_valid), 64'd0);
    checkOutput("mrst_c", 64'(c), 64'd0);
    checkOutput("mrst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    doOp("bgtz", 4'd12, 32'd5, 32'd0, 32'd1, 32'd0, 2'b10, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
